tinyalu_sched: RTL and testbench

Round-robin scheduler that shares a single TinyALU among `NUM_REQ` independent requesters. It accepts one operation at a time from the requester ports, drives the ALU `A`/`B`/`op`/`start` pins, and waits for `done`. It then returns the 16-bit result tagged with the requester index. It sits between the testbench-facing/agent-side operation sources and the `tinyalu` datapath, and owns the `start`/`done` handshake on the ALU.

---
 rtl/tinyalu_sched.sv | 155 +++++++++++++++
 tb/tb_tinyalu_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_sched.sv
// Round-robin scheduler sharing one TinyALU among NUM_REQ requesters.
// Owns the ALU start/done handshake and returns id-tagged 16-bit results.
//
//   state | meaning
//   IDLE  | arbitrate; latch the granted request
//   ISSUE | alu_start high with latched operands, waiting for done or timeout
//   RESP  | one-cycle rsp_valid pulse; alu_start low
module tinyalu_sched #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   input  logic [3*NUM_REQ-1:0]   req_op,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [15:0]            rsp_result,
   output logic                   rsp_err,
   output logic [7:0]             alu_a,
   output logic [7:0]             alu_b,
   output logic [2:0]             alu_op,
   output logic                   alu_start,
   input  logic                   alu_done,
   input  logic [15:0]            alu_result,
   output logic                   busy
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [7:0]        a_q, a_d;
   logic [7:0]        b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       res_q, res_d;
   logic              err_q, err_d;

   logic [ID_W-1:0]   gnt;
   logic              gnt_found;
   logic [ID_W:0]     cand;
   logic [2:0]        gnt_op;
   logic              gnt_legal;

   // Search upward from last_grant+1; last_grant itself is checked last.
   always_comb begin
      gnt       = '0;
      gnt_found = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt       = cand[ID_W-1:0];
         end
      end
   end

   assign gnt_op    = req_op[3*int'(gnt) +: 3];
   assign gnt_legal = (gnt_op != 3'd0) && (gnt_op <= 3'd4);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      err_d     = err_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               req_ready = NUM_REQ'(1) << gnt;
               last_d    = gnt;
               id_d      = gnt;
               a_d       = req_a[8*int'(gnt) +: 8];
               b_d       = req_b[8*int'(gnt) +: 8];
               op_d      = gnt_op;
               res_d     = '0;
               cnt_d     = CNT_W'(TIMEOUT - 1);
               if (gnt_legal) begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end else begin
                  err_d   = (gnt_op != 3'd0);
                  state_d = RESP;
               end
            end
         end
         ISSUE: begin
            // done is tested before the terminal count so it wins a tie
            if (alu_done) begin
               res_d   = alu_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == '0) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= ID_W'(NUM_REQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign alu_start  = (state_q == ISSUE);
   assign alu_a      = alu_start ? a_q  : '0;
   assign alu_b      = alu_start ? b_q  : '0;
   assign alu_op     = alu_start ? op_q : '0;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tinyalu_sched.sv
// Scoreboard bench for tinyalu_sched with a behavioural TinyALU whose
// latency and hang behaviour are set per test.
module tb_tinyalu_sched;
   localparam int N  = 4;
   localparam int TO = 16;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [8*N-1:0]  req_a;
   logic [8*N-1:0]  req_b;
   logic [3*N-1:0]  req_op;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [15:0]     rsp_result;
   logic            rsp_err;
   logic [7:0]      alu_a;
   logic [7:0]      alu_b;
   logic [2:0]      alu_op;
   logic            alu_start;
   logic            alu_done;
   logic [15:0]     alu_result;
   logic            busy;

   tinyalu_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // behavioural ALU: done pulses lat cycles after start rises unless hung
   int          lat    = 1;
   logic        hang   = 1'b0;
   logic        spur   = 1'b0;
   int          acnt   = 0;
   logic        done_r = 1'b0;
   logic [15:0] ares   = 16'h0;
   assign alu_done   = done_r | spur;
   assign alu_result = ares;

   always @(posedge clk) begin
      if (!alu_start) begin
         acnt   <= 0;
         done_r <= 1'b0;
      end else if (done_r) begin
         done_r <= 1'b0;
      end else if (!hang && acnt == lat - 1) begin
         done_r <= 1'b1;
         ares   <= alu_fn(alu_op, alu_a, alu_b);
      end else begin
         acnt <= acnt + 1;
      end
   end

   typedef struct {
      logic [IW-1:0] id;
      logic [15:0]   res;
      logic          err;
   } rsp_t;
   rsp_t        sb[$];
   rsp_t        got;
   logic [18:0] exp_pins = '0;

   always @(negedge clk) begin
      if (!reset) begin
         if (alu_start) check("pins_hold", {alu_a, alu_b, alu_op}, exp_pins);
         else           check("pins_zero", {alu_a, alu_b, alu_op}, 0);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("unexp_rsp", rsp_valid, 0);
            end else begin
               got = sb.pop_front();
               check("rsp_id", rsp_id, got.id);
               check("rsp_result", rsp_result, got.res);
               check("rsp_err", rsp_err, got.err);
            end
         end
      end
   end

   function automatic rsp_t expect_of(input int id, input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input bit tmo);
      rsp_t r;
      r.id  = IW'(id);
      r.res = 16'h0;
      r.err = 1'b0;
      if (tmo || op > 3'd4) r.err = 1'b1;
      else if (op != 3'd0)  r.res = alu_fn(op, a, b);
      return r;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
      req_op[3*id +: 3] = op;
   endtask

   // Returns in the cycle after the accept, #1 past its posedge.
   task automatic do_req(input int id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit tmo, output int n_acc);
      @(posedge clk); #1;
      set_req(id, op, a, b);
      req_valid[id] = 1'b1;
      n_acc = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            n_acc = cyc;
            break;
         end
      end
      if (n_acc < 0) begin
         check("ready_timeout", req_ready[id], 1);
      end else begin
         check("ready_onehot", req_ready, 1 << id);
         exp_pins = {a, b, op};
         sb.push_back(expect_of(id, op, a, b, tmo));
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output int c);
      c = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check("rsp_timeout", rsp_valid, 1);
   endtask

   task automatic count_start(output int hi);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (alu_start) hi++;
         else break;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("sb_drain", sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   n, c, hi, gi;
      rsp_t dropped;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_result}, 0);
      check("rst_alu", {alu_start, alu_a, alu_b, alu_op}, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // contention: all four hold xor requests
      for (int i = 0; i < N; i++) set_req(i, 3'd3, 8'(i), 8'hF0);
      req_valid = '1;
      for (int g = 0; g < 5; g++) begin
         gi = -1;
         for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (|req_ready) begin
               gi = oh_idx(req_ready);
               break;
            end
         end
         check("grant_order", gi, g % N);
         if (gi >= 0) begin
            check("grant_onehot", $countones(req_ready), 1);
            exp_pins = {8'(gi), 8'hF0, 3'd3};
            sb.push_back(expect_of(gi, 3'd3, 8'(gi), 8'hF0, 1'b0));
         end
         if (g == 4) begin
            @(posedge clk); #1;
            req_valid = '0;
         end
      end
      drain();

      // single add
      lat = 1;
      do_req(0, 3'd1, 8'h12, 8'h34, 1'b0, n);
      check("add_start", alu_start, 1);
      wait_rsp(c);
      check("add_result", rsp_result, 16'h0046);
      check("add_lat", c - n, 3);

      // multiply with multi-cycle latency
      lat = 3;
      do_req(2, 3'd4, 8'hFF, 8'hFF, 1'b0, n);
      wait_rsp(c);
      check("mul_result", rsp_result, 16'hFE01);
      check("mul_id", rsp_id, 2);
      check("mul_lat", c - n, 5);
      lat = 1;

      // no-op and illegal respond at N+1 without starting the ALU
      do_req(1, 3'd0, 8'h11, 8'h22, 1'b0, n);
      check("noop_start", alu_start, 0);
      @(negedge clk);
      check("noop_rsp", rsp_valid, 1);
      check("noop_err", rsp_err, 0);
      do_req(3, 3'd6, 8'h33, 8'h44, 1'b0, n);
      check("ill_start", alu_start, 0);
      @(negedge clk);
      check("ill_rsp", rsp_valid, 1);
      check("ill_err", rsp_err, 1);
      check("ill_result", rsp_result, 0);

      // timeout: ALU never answers
      hang = 1'b1;
      do_req(1, 3'd1, 8'h05, 8'h06, 1'b1, n);
      count_start(hi);
      check("tmo_len", hi, TO);
      check("tmo_rsp", rsp_valid, 1);
      check("tmo_err", rsp_err, 1);
      hang = 1'b0;
      do_req(2, 3'd2, 8'hF0, 8'h3C, 1'b0, n);
      wait_rsp(c);
      check("after_tmo", rsp_result, 16'h0030);

      // done on the terminal-count cycle wins
      lat = TO - 1;
      do_req(0, 3'd3, 8'hAA, 8'h55, 1'b0, n);
      count_start(hi);
      check("tie_len", hi, TO);
      check("tie_rsp", rsp_valid, 1);
      check("tie_err", rsp_err, 0);
      check("tie_result", rsp_result, 16'h00FF);
      lat = 1;

      // spurious done while idle
      @(posedge clk); #1;
      spur = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("spur_busy", busy, 0);
      end
      @(posedge clk); #1;
      spur = 1'b0;

      // reset during a mul from req0
      lat = 10;
      do_req(0, 3'd4, 8'h03, 8'h07, 1'b0, n);
      @(posedge clk); #1;
      reset = 1'b1;
      dropped = sb.pop_back();
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_start", alu_start, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rsp", rsp_valid, 0);
      repeat (15) @(negedge clk);
      lat = 1;
      @(posedge clk); #1;
      set_req(0, 3'd1, 8'h01, 8'h02);
      set_req(1, 3'd1, 8'h03, 8'h04);
      req_valid = 4'b0011;
      gi = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (|req_ready) begin
            gi = oh_idx(req_ready);
            break;
         end
      end
      check("rst_ptr_grant", gi, 0);
      if (gi >= 0) begin
         exp_pins = {req_a[8*gi +: 8], req_b[8*gi +: 8], 3'd1};
         sb.push_back(expect_of(gi, 3'd1, req_a[8*gi +: 8], req_b[8*gi +: 8], 1'b0));
      end
      @(posedge clk); #1;
      req_valid = '0;
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
